// File: rtl/ternary_dmem_arbiter_pkg.sv
// Shared ternary types for the data-memory arbiter: trit encoding, word aliases,
// arbiter state enum and a balanced-ternary literal helper.
package ternary_pkg;

  // Balanced trit: 00 = 0, 01 = +1, 11 = -1 (10 unused).
  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_Z = 2'b00;
  localparam trit_t TRIT_P = 2'b01;
  localparam trit_t TRIT_N = 2'b11;

  typedef trit_t [8:0]  trit9_t;
  typedef trit_t [26:0] trit27_t;

  localparam trit9_t  TRIT9_ZERO  = '0;
  localparam trit27_t TRIT27_ZERO = '0;

  localparam int unsigned ARB_CNT_W = 16;

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} arb_state_t;

  function automatic trit27_t int_to_trit27(input int value);
    trit27_t res;
    int      v;
    int      m;
    res = TRIT27_ZERO;
    v   = value;
    for (int i = 0; i < 27; i++) begin
      m = ((v % 3) + 3) % 3;
      if (m == 0) begin
        res[i] = TRIT_Z;
        v      = v / 3;
      end else if (m == 1) begin
        res[i] = TRIT_P;
        v      = (v - 1) / 3;
      end else begin
        res[i] = TRIT_N;
        v      = (v + 1) / 3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ternary_dmem_arbiter_if.sv
// One requester's access channel into the data-memory arbiter.
interface ternary_dmem_arbiter_if #(
   parameter int unsigned TRIT_WIDTH = 27,
   parameter int unsigned ADDR_WIDTH = 9
);
   import ternary_pkg::*;

   logic                        valid;
   logic                        we;
   logic                        lock;
   trit_t [ADDR_WIDTH-1:0]      addr;
   trit_t [TRIT_WIDTH-1:0]      wdata;
   logic                        ready;
   logic                        rvalid;
   trit_t [TRIT_WIDTH-1:0]      rdata;

   modport master (
      output valid, we, lock, addr, wdata,
      input  ready, rvalid, rdata
   );

   modport slave (
      input  valid, we, lock, addr, wdata,
      output ready, rvalid, rdata
   );

endinterface

// File: rtl/ternary_rr_arb2.sv
// Two-way picker: round-robin on last_grant, or fixed priority to port 0.
module ternary_rr_arb2 #(
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // 1 = port 1 was granted most recently.
   logic last_q;

   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ((FIXED_PRIO != 0) || last_q) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (gnt[0]) begin
         last_q <= 1'b0;
      end else if (gnt[1]) begin
         last_q <= 1'b1;
      end
   end

endmodule

// File: rtl/ternary_dmem_arbiter.sv
// Shares one data-memory port between the LSU (req0) and the debug/DMA loader (req1),
// with registered read return and a lock for atomic sequences guarded by a watchdog.
module ternary_dmem_arbiter
   import ternary_pkg::*;
#(
   parameter int unsigned TRIT_WIDTH   = 27,
   parameter int unsigned ADDR_WIDTH   = 9,
   parameter int unsigned FIXED_PRIO   = 0,
   parameter int unsigned LOCK_TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ternary_dmem_arbiter_if.slave  req0,
   ternary_dmem_arbiter_if.slave  req1,
   output trit_t [ADDR_WIDTH-1:0] dmem_addr,
   output trit_t [TRIT_WIDTH-1:0] dmem_wdata,
   output logic                   dmem_we,
   output logic                   dmem_re,
   input  trit_t [TRIT_WIDTH-1:0] dmem_rdata,
   output logic                   lock_err,
   output logic [ARB_CNT_W-1:0]   conflict_cnt
);

   localparam int unsigned CntW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(LOCK_TIMEOUT - 1);

   arb_state_t             state_q, state_d;
   logic [CntW-1:0]        lock_cnt_q, lock_cnt_d;
   logic                   lock_err_q, lock_err_d;
   logic [ARB_CNT_W-1:0]   conflict_q, conflict_d;
   logic [1:0]             req_raw, req_mask, gnt;
   logic                   own_gnt, own_lock;
   logic                   rvalid0_q, rvalid1_q;
   trit_t [TRIT_WIDTH-1:0] rdata0_q, rdata1_q;

   assign req_raw = {req1.valid, req0.valid};

   // Grants are suppressed while reset is held so an unclocked write never lands.
   always_comb begin
      req_mask = req_raw;
      case (state_q)
         LOCK0:   req_mask[1] = 1'b0;
         LOCK1:   req_mask[0] = 1'b0;
         default: req_mask    = req_raw;
      endcase
      if (!rst_n) begin
         req_mask = 2'b00;
      end
   end

   ternary_rr_arb2 #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_pick (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_mask),
      .gnt   (gnt)
   );

   assign req0.ready = gnt[0];
   assign req1.ready = gnt[1];

   always_comb begin
      dmem_addr  = '0;
      dmem_wdata = '0;
      dmem_we    = 1'b0;
      dmem_re    = 1'b0;
      if (gnt[0]) begin
         dmem_addr  = req0.addr;
         dmem_wdata = req0.wdata;
         dmem_we    = req0.we;
         dmem_re    = ~req0.we;
      end else if (gnt[1]) begin
         dmem_addr  = req1.addr;
         dmem_wdata = req1.wdata;
         dmem_we    = req1.we;
         dmem_re    = ~req1.we;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         rvalid0_q <= gnt[0] & ~req0.we;
         rvalid1_q <= gnt[1] & ~req1.we;
         if (gnt[0] && !req0.we) begin
            rdata0_q <= dmem_rdata;
         end
         if (gnt[1] && !req1.we) begin
            rdata1_q <= dmem_rdata;
         end
      end
   end

   assign req0.rvalid = rvalid0_q;
   assign req0.rdata  = rdata0_q;
   assign req1.rvalid = rvalid1_q;
   assign req1.rdata  = rdata1_q;

   // The lock owner's signals, so both lock states share one transition block.
   always_comb begin
      own_gnt  = (state_q == LOCK1) ? gnt[1]    : gnt[0];
      own_lock = (state_q == LOCK1) ? req1.lock : req0.lock;
   end

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      lock_err_d = lock_err_q;
      case (state_q)
         ARB: begin
            if (gnt[0] && req0.lock) begin
               state_d    = LOCK0;
               lock_cnt_d = '0;
            end else if (gnt[1] && req1.lock) begin
               state_d    = LOCK1;
               lock_cnt_d = '0;
            end
         end
         LOCK0, LOCK1: begin
            if (own_gnt) begin
               lock_cnt_d = '0;
               if (!own_lock) begin
                  state_d = ARB;
               end
            end else if (!own_lock) begin
               state_d = ARB;
            end else if (lock_cnt_q == CntMax) begin
               state_d    = ARB;
               lock_err_d = 1'b1;
            end else begin
               lock_cnt_d = lock_cnt_q + CntW'(1);
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_comb begin
      conflict_d = conflict_q;
      if ((&req_raw) && (conflict_q != {ARB_CNT_W{1'b1}})) begin
         conflict_d = conflict_q + ARB_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB;
         lock_cnt_q <= '0;
         lock_err_q <= 1'b0;
         conflict_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         lock_err_q <= lock_err_d;
         conflict_q <= conflict_d;
      end
   end

   assign lock_err     = lock_err_q;
   assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_ternary_dmem_arbiter.sv
// Scoreboarded bench: stimulus pushes expected read returns, a negedge monitor pops them.
module tb_ternary_dmem_arbiter;
   import ternary_pkg::*;

   typedef struct {
      trit27_t data;
      int      due;
   } exp_t;

   logic    clk = 1'b0;
   logic    rst_n;
   int      total = 0;
   int      bad = 0;
   int      cyc = 0;
   exp_t    q0[$];
   exp_t    q1[$];

   trit27_t mem_rr [1024];
   trit27_t mem_fp [1024];

   trit9_t  addr_rr, addr_fp;
   trit27_t wdata_rr, wdata_fp, rdata_rr, rdata_fp;
   logic    we_rr, re_rr, we_fp, re_fp;
   logic    lock_err_rr, lock_err_fp;
   logic [15:0] cnt_rr, cnt_fp;
   logic [17:0] addr_rr_flat, addr_fp_flat;

   ternary_dmem_arbiter_if #(.TRIT_WIDTH(27), .ADDR_WIDTH(9)) rq0 ();
   ternary_dmem_arbiter_if #(.TRIT_WIDTH(27), .ADDR_WIDTH(9)) rq1 ();
   ternary_dmem_arbiter_if #(.TRIT_WIDTH(27), .ADDR_WIDTH(9)) fq0 ();
   ternary_dmem_arbiter_if #(.TRIT_WIDTH(27), .ADDR_WIDTH(9)) fq1 ();

   assign fq0.valid = rq0.valid;
   assign fq0.we    = rq0.we;
   assign fq0.lock  = rq0.lock;
   assign fq0.addr  = rq0.addr;
   assign fq0.wdata = rq0.wdata;
   assign fq1.valid = rq1.valid;
   assign fq1.we    = rq1.we;
   assign fq1.lock  = rq1.lock;
   assign fq1.addr  = rq1.addr;
   assign fq1.wdata = rq1.wdata;

   ternary_dmem_arbiter #(
      .TRIT_WIDTH(27), .ADDR_WIDTH(9), .FIXED_PRIO(0), .LOCK_TIMEOUT(16)
   ) dut_rr (
      .clk(clk), .rst_n(rst_n), .req0(rq0), .req1(rq1),
      .dmem_addr(addr_rr), .dmem_wdata(wdata_rr), .dmem_we(we_rr), .dmem_re(re_rr),
      .dmem_rdata(rdata_rr), .lock_err(lock_err_rr), .conflict_cnt(cnt_rr)
   );

   ternary_dmem_arbiter #(
      .TRIT_WIDTH(27), .ADDR_WIDTH(9), .FIXED_PRIO(1), .LOCK_TIMEOUT(16)
   ) dut_fp (
      .clk(clk), .rst_n(rst_n), .req0(fq0), .req1(fq1),
      .dmem_addr(addr_fp), .dmem_wdata(wdata_fp), .dmem_we(we_fp), .dmem_re(re_fp),
      .dmem_rdata(rdata_fp), .lock_err(lock_err_fp), .conflict_cnt(cnt_fp)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: combinational read, write at the clock edge.
   assign addr_rr_flat = addr_rr;
   assign addr_fp_flat = addr_fp;
   assign rdata_rr = mem_rr[addr_rr_flat[9:0]];
   assign rdata_fp = mem_fp[addr_fp_flat[9:0]];

   always @(posedge clk) begin
      if (we_rr) mem_rr[addr_rr_flat[9:0]] <= wdata_rr;
      if (we_fp) mem_fp[addr_fp_flat[9:0]] <= wdata_fp;
   end

   function automatic trit27_t t27(input int v);
      return int_to_trit27(v);
   endfunction

   function automatic trit9_t a9(input int v);
      trit27_t t;
      t = int_to_trit27(v);
      return t[8:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int p, input int v);
      exp_t e;
      e.data = t27(v);
      e.due  = cyc + 1;
      if (p == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic drv(input int p, input logic v, input logic w, input logic lk,
                      input int a, input int d);
      if (p == 0) begin
         rq0.valid = v; rq0.we = w; rq0.lock = lk; rq0.addr = a9(a); rq0.wdata = t27(d);
      end else begin
         rq1.valid = v; rq1.we = w; rq1.lock = lk; rq1.addr = a9(a); rq1.wdata = t27(d);
      end
   endtask

   task automatic idle_all();
      drv(0, 1'b0, 1'b0, 1'b0, 0, 0);
      drv(1, 1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rq0.rvalid) begin
         if (q0.size() == 0) begin
            chk("rvalid0_unexpected", 1, 0);
         end else begin
            e = q0.pop_front();
            chk("rdata0", rq0.rdata, e.data);
            chk("rvalid0_cycle", cyc, e.due);
         end
      end
      if (rq1.rvalid) begin
         if (q1.size() == 0) begin
            chk("rvalid1_unexpected", 1, 0);
         end else begin
            e = q1.pop_front();
            chk("rdata1", rq1.rdata, e.data);
            chk("rvalid1_cycle", cyc, e.due);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_rr[i] = TRIT27_ZERO;
         mem_fp[i] = TRIT27_ZERO;
      end
      mem_rr[a9(10)[9:0]] = t27(7);
      mem_rr[a9(20)[9:0]] = t27(-8);
      mem_rr[a9(3)[9:0]]  = t27(41);
      mem_fp[a9(10)[9:0]] = t27(7);
      mem_fp[a9(20)[9:0]] = t27(-8);
      idle_all();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready0", rq0.ready, 0);
      chk("rst_rvalid0", rq0.rvalid, 0);
      chk("rst_rdata1", rq1.rdata, TRIT27_ZERO);
      chk("rst_lock_err", lock_err_rr, 0);
      chk("rst_conflict", cnt_rr, 0);
      chk("rst_dmem_re", re_rr, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Both read every cycle: round-robin alternates from port 0, fixed stays on port 0.
      for (int i = 0; i < 4; i++) begin
         tick();
         drv(0, 1'b1, 1'b0, 1'b0, 10, 0);
         drv(1, 1'b1, 1'b0, 1'b0, 20, 0);
         if (i % 2 == 0) push(0, 7);
         else            push(1, -8);
         @(negedge clk);
         chk("rr_ready0", rq0.ready, (i % 2 == 0));
         chk("rr_ready1", rq1.ready, (i % 2 == 1));
         chk("fp_ready0", fq0.ready, 1);
         chk("fp_ready1", fq1.ready, 0);
      end
      tick();
      idle_all();
      @(negedge clk);
      chk("rr_conflict4", cnt_rr, 4);
      chk("fp_conflict4", cnt_fp, 4);
      chk("fp_rdata0", fq0.rdata, t27(7));
      chk("fp_rvalid1", fq1.rvalid, 0);

      // Port 0 write then read-back of the same word.
      tick();
      drv(0, 1'b1, 1'b1, 1'b0, 5, 100);
      @(negedge clk);
      chk("wr_ready0", rq0.ready, 1);
      chk("wr_ready1", rq1.ready, 0);
      chk("wr_we", we_rr, 1);
      chk("wr_addr", addr_rr, a9(5));
      chk("wr_wdata", wdata_rr, t27(100));
      tick();
      drv(0, 1'b1, 1'b0, 1'b0, 5, 0);
      push(0, 100);
      @(negedge clk);
      chk("rd_ready0", rq0.ready, 1);
      chk("rd_re", re_rr, 1);
      chk("rd_we", we_rr, 0);
      tick();
      idle_all();
      @(negedge clk);
      chk("rd_rvalid1_idle", rq1.rvalid, 0);

      // Port 1 locked read-modify-write of +3 while port 0 keeps asking.
      tick();
      drv(0, 1'b1, 1'b0, 1'b0, 10, 0);
      drv(1, 1'b1, 1'b0, 1'b1, 3, 0);
      push(1, 41);
      @(negedge clk);
      chk("lk_ready1", rq1.ready, 1);
      chk("lk_ready0", rq0.ready, 0);
      tick();
      drv(1, 1'b1, 1'b1, 1'b0, 3, 42);
      @(negedge clk);
      chk("lk_wr_ready0", rq0.ready, 0);
      chk("lk_wr_ready1", rq1.ready, 1);
      chk("lk_wr_we", we_rr, 1);
      chk("lk_wr_wdata", wdata_rr, t27(42));
      tick();
      drv(1, 1'b0, 1'b0, 1'b0, 0, 0);
      push(0, 7);
      @(negedge clk);
      chk("lk_after_ready0", rq0.ready, 1);
      tick();
      drv(0, 1'b0, 1'b0, 1'b0, 0, 0);
      drv(1, 1'b1, 1'b0, 1'b0, 3, 0);
      push(1, 42);
      @(negedge clk);
      chk("lk_readback_ready1", rq1.ready, 1);
      chk("lk_conflict6", cnt_rr, 6);

      // Port 0 locks then idles with lock held until the watchdog fires.
      tick();
      drv(1, 1'b0, 1'b0, 1'b0, 0, 0);
      drv(0, 1'b1, 1'b0, 1'b1, 10, 0);
      push(0, 7);
      @(negedge clk);
      chk("to_ready0", rq0.ready, 1);
      for (int k = 1; k <= 16; k++) begin
         tick();
         drv(0, 1'b0, 1'b0, 1'b1, 0, 0);
         drv(1, 1'b1, 1'b0, 1'b0, 20, 0);
         @(negedge clk);
         chk("to_held_ready1", rq1.ready, 0);
         if (k == 16) chk("to_err_before", lock_err_rr, 0);
      end
      tick();
      push(1, -8);
      @(negedge clk);
      chk("to_release_ready1", rq1.ready, 1);
      chk("to_err_set", lock_err_rr, 1);
      tick();
      idle_all();
      tick();
      @(negedge clk);
      chk("to_err_sticky", lock_err_rr, 1);

      // Async reset while port 1 holds the lock with a write pending.
      tick();
      drv(1, 1'b1, 1'b0, 1'b1, 3, 0);
      push(1, 42);
      @(negedge clk);
      chk("rs_ready1", rq1.ready, 1);
      tick();
      drv(1, 1'b1, 1'b1, 1'b1, 3, 99);
      @(negedge clk);
      chk("rs_locked_ready1", rq1.ready, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rs_now_ready1", rq1.ready, 0);
      chk("rs_now_we", we_rr, 0);
      chk("rs_now_rvalid1", rq1.rvalid, 0);
      chk("rs_now_rdata1", rq1.rdata, TRIT27_ZERO);
      chk("rs_now_err", lock_err_rr, 0);
      chk("rs_now_conflict", cnt_rr, 0);
      @(posedge clk);
      @(negedge clk);
      chk("rs_held_rvalid1", rq1.rvalid, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drv(0, 1'b1, 1'b0, 1'b0, 10, 0);
      drv(1, 1'b1, 1'b0, 1'b0, 20, 0);
      push(0, 7);
      @(negedge clk);
      chk("rs_arb_ready0", rq0.ready, 1);
      chk("rs_arb_ready1", rq1.ready, 0);
      chk("rs_arb_rvalid1", rq1.rvalid, 0);
      tick();
      drv(0, 1'b0, 1'b0, 1'b0, 0, 0);
      drv(1, 1'b1, 1'b0, 1'b0, 3, 0);
      push(1, 42);
      @(negedge clk);
      chk("rs_nowrite_ready1", rq1.ready, 1);
      tick();
      idle_all();
      repeat (3) @(negedge clk);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ternary_dmem_arbiter.md
Name: ternary_dmem_arbiter

Overview:
Two-requester arbiter that shares the single data-memory read/write port between the CPU load/store unit (port 0) and the debug/DMA loader (port 1).
- Memory read is combinational and write commits at the clock edge, so the arbiter selects one requester per cycle.
- Read data is registered and returned one cycle after the grant.
- Supports round-robin or fixed priority, plus a lock for atomic read-modify-write sequences with a timeout watchdog.

Parameters:
TRIT_WIDTH, 27, data word width in trits
ADDR_WIDTH, 9, address width in trits
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins a conflict
LOCK_TIMEOUT, 16, max cycles a lock may be held before forced release (must be at least 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req0_valid / req1_valid  in  1  access request
req0_we / req1_we  in  1  1 = write, 0 = read
req0_lock / req1_lock  in  1  hold ownership after this access
req0_addr / req1_addr  in  trit_t[ADDR_WIDTH]  word address
req0_wdata / req1_wdata  in  trit_t[TRIT_WIDTH]  write data
req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
req0_rvalid / req1_rvalid  out  1  read data valid (one-cycle pulse)
req0_rdata / req1_rdata  out  trit_t[TRIT_WIDTH]  read data
dmem_addr  out  trit_t[ADDR_WIDTH]  to memory
dmem_wdata  out  trit_t[TRIT_WIDTH]  to memory
dmem_we  out  1  memory write enable
dmem_re  out  1  memory read enable
dmem_rdata  in  trit_t[TRIT_WIDTH]  from memory (combinational)
lock_err  out  1  sticky: a lock timeout occurred
conflict_cnt  out  16  saturating count of cycles with both requests valid

Behaviour:
- Reset (async, rst_n low):
  - FSM = ARB, last_grant = 1 (so port 0 wins the first conflict), lock counter = 0.
  - rvalid = 0 on both ports; rdata = TRIT27_ZERO.
  - lock_err = 0, conflict_cnt = 0.
- Reset asserted mid-lock drops the lock immediately. A write that has not reached a clock edge is not performed.
- Grant decision (combinational):
  - ARB state:
    - Only one valid: that port is granted.
    - Both valid, round-robin: grant the port that is not last_grant.
    - Both valid, FIXED_PRIO = 1: grant port 0.
  - LOCKn state: only port n can be granted. The other port's ready = 0.
- reqN_ready = grant to N.
- Memory drive:
  - Grant: dmem_addr/wdata come from the granted port; dmem_we = granted we; dmem_re = granted & ~we.
  - No grant: addr = TRIT9_ZERO, wdata = TRIT27_ZERO, we = 0, re = 0.
- Read response:
  - A granted read in cycle N registers dmem_rdata into that port's rdata. rvalid pulses high for one cycle in N+1.
  - rdata holds its value until the next read on that port.
  - There is no response backpressure.
- Write: commits at the posedge ending the grant cycle. A read of the same address in cycle N+1 returns the new data.
- last_grant updates on every grant.
- Lock FSM:
  - ARB -> LOCKn: on a granted access with reqN_lock = 1. Counter loads 0.
  - LOCKn -> LOCKn: while port n issues locked accesses. Counter resets to 0 on each granted access, otherwise increments.
  - LOCKn -> ARB:
    - on a granted access with lock = 0 (that access is performed);
    - on any cycle with reqN_valid = 0 and reqN_lock = 0;
    - forced when counter reaches LOCK_TIMEOUT-1 without an access. This sets lock_err.
  - Once lock_err is set it clears only on reset.
- conflict_cnt increments on each cycle with both valid, in any state. Saturates at 0xFFFF.
- The arbiter passes addresses through unchanged; out-of-range handling belongs to the memory.

Decomposition:
- ternary_pkg gains:
  - the typedef enum arb_state_t {ARB, LOCK0, LOCK1};
  - the constant ARB_CNT_W = 16.
- trit_t, TRIT9_ZERO and TRIT27_ZERO are already in the package.
- One natural sub-module: ternary_rr_arb2, a two-way round-robin/fixed picker with a last_grant flop.
- Muxing, the response registers and the lock FSM stay in the top level.

Test Plan:
- Port 0 writes addr +5 = +100, then reads addr +5 -> ready high both cycles; req0_rvalid one cycle later with rdata = +100; req1 signals idle.
- Both ports read every cycle for 4 cycles, round-robin -> grants 0,1,0,1; conflict_cnt = 4; each rvalid is 1 cycle after its grant.
- Same traffic with FIXED_PRIO = 1 -> port 0 granted all 4 cycles; req1_ready stays 0.
- Port 1 lock-read addr +3, then lock-free write addr +3 = rdata+1 while port 0 requests constantly -> req0_ready = 0 until port 1 releases; memory +3 is incremented; port 0 is granted the next cycle.
- Port 0 locks, then idles with lock held (valid = 0, lock = 1) for 16 cycles, LOCK_TIMEOUT = 16 -> forced to ARB after 16 cycles; lock_err = 1 stays set; port 1 granted afterwards.
- Assert rst_n low asynchronously while in LOCK1 with a read in flight -> all outputs are at reset values immediately; no rvalid follows; the FSM is in ARB after release.
